vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Top-level controller for the vending datapath.
- Accumulates coin credit from nickel, dime and quarter pulses.
- On a product select, drives the dispenser motor through a req/ack handshake.
- Pays out remaining credit one nickel at a time through a change-ejector handshake; a dispenser timeout triggers a full refund.

Parameters:
- PRICE, 20, product price in cents; must be a multiple of 5 and 5..MAX_CREDIT.
- MAX_CREDIT, 95, credit ceiling in cents; must be a multiple of 5.
- CREDIT_W, 7, credit register width; must hold MAX_CREDIT.
- VEND_TIMEOUT, 16, cycles to wait for vend_ack before declaring a fault (>=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- nin  in  1  nickel inserted, one-cycle pulse.
- din  in  1  dime inserted, one-cycle pulse.
- qin  in  1  quarter inserted, one-cycle pulse.
- sel  in  1  buyer vend request, sampled only in IDLE.
- cancel  in  1  buyer refund request, sampled only in IDLE.
- vend_req  out  1  dispenser motor request, level.
- vend_ack  in  1  dispenser done, one-cycle pulse.
- chg_req  out  1  eject-one-nickel request, level.
- chg_ack  in  1  nickel ejected, one-cycle pulse.
- coin_rej  out  1  coin-return gate pulse for a rejected coin.
- vend_fail  out  1  dispenser timeout pulse.
- credit  out  CREDIT_W  current credit in cents.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; credit=0; all outputs 0; timer=0.
- All outputs are registered. Each input is sampled at a clock edge and its effect is visible the next cycle.

Coin handling:
- Coin value: nin=5, din=10, qin=25.
- Accept only in IDLE, with exactly one coin bit set, and only if credit+value <= MAX_CREDIT.
- An accepted coin adds its value to credit next cycle.
- Any other coin event is rejected: coin_rej=1 for exactly 1 cycle, and credit is unchanged. This covers:
  - more than one coin bit set in a cycle;
  - a coin that would overflow MAX_CREDIT;
  - any coin while in VEND or PAYOUT.

IDLE:
- sel with credit>=PRICE: go to VEND; credit -= PRICE. The credit test uses registered credit, before any same-cycle coin.
- A coin accepted in the same cycle is still added, so credit_next = credit - PRICE + value.
- sel with credit<PRICE: ignored.
- cancel with credit>0, when no affordable sel is present: go to PAYOUT. sel has priority over cancel.
- cancel with credit=0: ignored.

VEND:
- vend_req=1 from the first VEND cycle and held until vend_ack is sampled.
- On vend_ack: vend_req=0 next cycle; go to PAYOUT if credit>0, else IDLE.
- The timer counts VEND cycles. If VEND_TIMEOUT cycles pass with no vend_ack:
  - vend_req=0;
  - vend_fail pulses 1 cycle;
  - credit += PRICE (refund);
  - go to PAYOUT.
- A vend_ack in the same cycle the timer expires counts as success.

PAYOUT:
- chg_req=1 while credit>0.
- Each sampled chg_ack: credit -= 5.
- When credit becomes 0, chg_req=0 in that same registered update and the state returns to IDLE.
- chg_ack while credit=0 or outside PAYOUT is ignored; credit never underflows.
- vend_ack outside VEND is ignored.

Other rules:
- busy = (state != IDLE).
- Credit is always a multiple of 5 and never exceeds MAX_CREDIT, including after a refund: credit_before_vend <= MAX_CREDIT.
- Reset asserted mid-VEND or mid-PAYOUT drops vend_req/chg_req immediately and discards credit.

Decomposition:
- Shared package vend_pkg:
  - state enum: IDLE, VEND, PAYOUT;
  - coin value constants: NICKEL=5, DIME=10, QUARTER=25;
  - function coin_value(nin, din, qin): returns the value, or 0 with an invalid flag.
- One sub-module, vend_timer:
  - ports: clk, reset, clear, enable;
  - output: expired, a level when count==VEND_TIMEOUT-1 and enable is high.
  - The FSM clears it on VEND entry.

Test Plan:
1. Reset, then nin, din, din, then sel → credit 5/15/25, then 5 after sel. vend_req high; vend_ack after 3 cycles → PAYOUT, chg_req high. One chg_ack → credit 0, chg_req low, IDLE.
2. Credit 90, then qin → coin_rej 1-cycle pulse, credit stays 90. nin → credit 95. din → rejected.
3. nin and din in the same cycle → coin_rej pulse, credit unchanged. Coin during VEND → coin_rej pulse, credit unchanged.
4. Credit 20, sel, no vend_ack → after 16 cycles vend_fail pulse, credit back to 20. Four chg_ack → credit 0, IDLE.
5. Credit 15, then sel → ignored. Credit 15 with sel+cancel in the same cycle → PAYOUT, three nickels returned. Credit 20 with sel+cancel → VEND.
6. reset=0 mid-PAYOUT with credit 10 → chg_req, credit and busy go to 0 without waiting for a clock edge. After release the block is in IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending sequencer.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, VEND, PAYOUT} vend_state_e;

  localparam logic [4:0] NICKEL  = 5'd5;
  localparam logic [4:0] DIME    = 5'd10;
  localparam logic [4:0] QUARTER = 5'd25;

  typedef struct packed {
    logic       invalid;
    logic [4:0] value;
  } coin_t;

  // No coin decodes as value 0 and valid; more than one coin bit is invalid.
  function automatic coin_t coin_value(input logic nin, input logic din, input logic qin);
    coin_t c;
    c.invalid = 1'b0;
    c.value   = 5'd0;
    case ({nin, din, qin})
      3'b000:  c.value = 5'd0;
      3'b100:  c.value = NICKEL;
      3'b010:  c.value = DIME;
      3'b001:  c.value = QUARTER;
      default: c.invalid = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Buyer, dispenser and change-ejector signals of the vending sequencer.
// Handshakes: vend_req/chg_req are levels held until the matching one-cycle
// ack is sampled on a rising edge; the request drops in the following cycle.
interface vend_if #(parameter int CREDIT_W = 7);
  logic                nin;
  logic                din;
  logic                qin;
  logic                sel;
  logic                cancel;
  logic                vend_req;
  logic                vend_ack;
  logic                chg_req;
  logic                chg_ack;
  logic                coin_rej;
  logic                vend_fail;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  vend_pkg::vend_state_e state;

  modport master (
    input  nin, din, qin, sel, cancel, vend_ack, chg_ack,
    output vend_req, chg_req, coin_rej, vend_fail, credit, busy, state
  );

  modport slave (
    output nin, din, qin, sel, cancel, vend_ack, chg_ack,
    input  vend_req, chg_req, coin_rej, vend_fail, credit, busy, state
  );
endinterface

// File: rtl/vend_timer.sv
// Dispenser watchdog: counts enabled cycles, flags the last allowed one.
module vend_timer #(
  parameter int VEND_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = (VEND_TIMEOUT > 2) ? $clog2(VEND_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(VEND_TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        count <= '0;
    else if (clear)                    count <= '0;
    else if (enable && count != LAST)  count <= count + 1'b1;
  end

  assign expired = enable && (count == LAST);
endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: coin credit, dispenser handshake with timeout refund,
// and nickel-by-nickel change payout.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE        = 20,
  parameter int MAX_CREDIT   = 95,
  parameter int CREDIT_W     = 7,
  parameter int VEND_TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   reset,
  vend_if.master bus
);
  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);

  vend_state_e         state, state_next;
  logic [CREDIT_W-1:0] credit, credit_next;
  logic vend_req, vend_req_next, chg_req, chg_req_next;
  logic coin_rej, coin_rej_next, vend_fail, vend_fail_next;
  logic timer_clear, expired;

  coin_t          coin;
  logic           coin_any, accept;
  logic [CW1-1:0] sum;

  assign coin     = coin_value(bus.nin, bus.din, bus.qin);
  assign coin_any = bus.nin | bus.din | bus.qin;
  assign sum      = {1'b0, credit} + CW1'(coin.value);
  assign accept   = (state == IDLE) && coin_any && !coin.invalid &&
                    (sum <= CW1'(MAX_CREDIT));

  vend_timer #(.VEND_TIMEOUT(VEND_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state == VEND),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      credit    <= '0;
      vend_req  <= 1'b0;
      chg_req   <= 1'b0;
      coin_rej  <= 1'b0;
      vend_fail <= 1'b0;
    end else begin
      state     <= state_next;
      credit    <= credit_next;
      vend_req  <= vend_req_next;
      chg_req   <= chg_req_next;
      coin_rej  <= coin_rej_next;
      vend_fail <= vend_fail_next;
    end
  end

  always_comb begin
    state_next     = state;
    credit_next    = credit;
    vend_req_next  = 1'b0;
    chg_req_next   = 1'b0;
    coin_rej_next  = coin_any && !accept;
    vend_fail_next = 1'b0;
    timer_clear    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) credit_next = sum[CREDIT_W-1:0];
        // Affordability uses registered credit; a same-cycle coin still lands.
        if (bus.sel && credit >= PRICE_C) begin
          state_next    = VEND;
          credit_next   = credit_next - PRICE_C;
          vend_req_next = 1'b1;
          timer_clear   = 1'b1;
        end else if (bus.cancel && credit != '0) begin
          state_next   = PAYOUT;
          chg_req_next = 1'b1;
        end
      end
      VEND: begin
        if (bus.vend_ack) begin
          state_next   = (credit != '0) ? PAYOUT : IDLE;
          chg_req_next = (credit != '0);
        end else if (expired) begin
          state_next     = PAYOUT;
          credit_next    = credit + PRICE_C;
          vend_fail_next = 1'b1;
          chg_req_next   = 1'b1;
        end else begin
          vend_req_next = 1'b1;
        end
      end
      PAYOUT: begin
        if (bus.chg_ack && credit != '0) credit_next = credit - NICKEL_C;
        chg_req_next = (credit_next != '0);
        if (credit_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.vend_req  = vend_req;
  assign bus.chg_req   = chg_req;
  assign bus.coin_rej  = coin_rej;
  assign bus.vend_fail = vend_fail;
  assign bus.credit    = credit;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with hand-computed expectations.
module tb_vend_sequencer;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vend_if #(.CREDIT_W(7)) bus ();

  vend_sequencer #(
    .PRICE(20), .MAX_CREDIT(95), .CREDIT_W(7), .VEND_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  // Inputs change just after a falling edge; outputs are checked there too.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic put(input logic n, input logic d, input logic q);
    bus.nin = n; bus.din = d; bus.qin = q;
    cycle();
    bus.nin = 1'b0; bus.din = 1'b0; bus.qin = 1'b0;
  endtask

  task automatic press(input logic s, input logic c);
    bus.sel = s; bus.cancel = c;
    cycle();
    bus.sel = 1'b0; bus.cancel = 1'b0;
  endtask

  task automatic pulse_vend_ack();
    bus.vend_ack = 1'b1;
    cycle();
    bus.vend_ack = 1'b0;
  endtask

  task automatic pulse_chg_ack();
    bus.chg_ack = 1'b1;
    cycle();
    bus.chg_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!bus.chg_req) break;
      pulse_chg_ack();
    end
  endtask

  task automatic test_reset();
    repeat (2) cycle();
    vectors++; if (bus.credit !== 7'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", bus.credit); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if ({bus.vend_req, bus.chg_req, bus.coin_rej, bus.vend_fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {bus.vend_req, bus.chg_req, bus.coin_rej, bus.vend_fail}); end
    rst_n = 1'b1;
    cycle();
    vectors++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
  endtask

  task automatic test_vend_with_change();
    put(1, 0, 0);
    vectors++; if (bus.credit !== 7'd5) begin errors++; $display("FAIL t1_nickel: got %0d expected 5", bus.credit); end
    put(0, 1, 0);
    vectors++; if (bus.credit !== 7'd15) begin errors++; $display("FAIL t1_dime1: got %0d expected 15", bus.credit); end
    put(0, 1, 0);
    vectors++; if (bus.credit !== 7'd25) begin errors++; $display("FAIL t1_dime2: got %0d expected 25", bus.credit); end
    press(1, 0);
    vectors++; if (bus.credit !== 7'd5) begin errors++; $display("FAIL t1_sel_credit: got %0d expected 5", bus.credit); end
    vectors++; if (bus.vend_req !== 1'b1) begin errors++; $display("FAIL t1_vend_req: got %b expected 1", bus.vend_req); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", bus.busy); end
    repeat (2) cycle();
    vectors++; if (bus.vend_req !== 1'b1) begin errors++; $display("FAIL t1_vend_req_held: got %b expected 1", bus.vend_req); end
    pulse_vend_ack();
    vectors++; if (bus.vend_req !== 1'b0) begin errors++; $display("FAIL t1_vend_req_drop: got %b expected 0", bus.vend_req); end
    vectors++; if (bus.chg_req !== 1'b1) begin errors++; $display("FAIL t1_chg_req: got %b expected 1", bus.chg_req); end
    vectors++; if (bus.state !== PAYOUT) begin errors++; $display("FAIL t1_payout: got %0d expected %0d", bus.state, PAYOUT); end
    pulse_chg_ack();
    vectors++; if (bus.credit !== 7'd0) begin errors++; $display("FAIL t1_change_credit: got %0d expected 0", bus.credit); end
    vectors++; if ({bus.chg_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL t1_idle: got %b expected 00", {bus.chg_req, bus.busy}); end
  endtask

  task automatic test_overflow();
    put(0, 0, 1); put(0, 0, 1); put(0, 0, 1); put(0, 1, 0); put(1, 0, 0);
    vectors++; if (bus.credit !== 7'd90) begin errors++; $display("FAIL t2_load90: got %0d expected 90", bus.credit); end
    put(0, 0, 1);
    vectors++; if (bus.coin_rej !== 1'b1) begin errors++; $display("FAIL t2_q_rej: got %b expected 1", bus.coin_rej); end
    vectors++; if (bus.credit !== 7'd90) begin errors++; $display("FAIL t2_q_credit: got %0d expected 90", bus.credit); end
    cycle();
    vectors++; if (bus.coin_rej !== 1'b0) begin errors++; $display("FAIL t2_rej_one_cycle: got %b expected 0", bus.coin_rej); end
    put(1, 0, 0);
    vectors++; if (bus.credit !== 7'd95) begin errors++; $display("FAIL t2_n_to_95: got %0d expected 95", bus.credit); end
    vectors++; if (bus.coin_rej !== 1'b0) begin errors++; $display("FAIL t2_n_accept: got %b expected 0", bus.coin_rej); end
    put(0, 1, 0);
    vectors++; if ({bus.coin_rej, bus.credit} !== {1'b1, 7'd95}) begin
      errors++; $display("FAIL t2_d_rej: got rej=%b credit=%0d expected rej=1 credit=95", bus.coin_rej, bus.credit); end
    press(0, 1);
    vectors++; if ({bus.chg_req, bus.state} !== {1'b1, PAYOUT}) begin
      errors++; $display("FAIL t2_cancel: got chg_req=%b state=%0d expected 1/%0d", bus.chg_req, bus.state, PAYOUT); end
    drain();
    vectors++; if ({bus.busy, bus.credit} !== {1'b0, 7'd0}) begin
      errors++; $display("FAIL t2_drain: got busy=%b credit=%0d expected 0/0", bus.busy, bus.credit); end
  endtask

  task automatic test_reject();
    put(0, 1, 0);
    put(1, 1, 0);
    vectors++; if ({bus.coin_rej, bus.credit} !== {1'b1, 7'd10}) begin
      errors++; $display("FAIL t3_multi: got rej=%b credit=%0d expected 1/10", bus.coin_rej, bus.credit); end
    put(0, 1, 0);
    press(1, 0);
    vectors++; if ({bus.vend_req, bus.credit} !== {1'b1, 7'd0}) begin
      errors++; $display("FAIL t3_vend: got req=%b credit=%0d expected 1/0", bus.vend_req, bus.credit); end
    put(0, 0, 1);
    vectors++; if ({bus.coin_rej, bus.credit} !== {1'b1, 7'd0}) begin
      errors++; $display("FAIL t3_vend_coin: got rej=%b credit=%0d expected 1/0", bus.coin_rej, bus.credit); end
    pulse_chg_ack();
    vectors++; if ({bus.credit, bus.state} !== {7'd0, VEND}) begin
      errors++; $display("FAIL t3_stray_chg_ack: got credit=%0d state=%0d expected 0/%0d", bus.credit, bus.state, VEND); end
    pulse_vend_ack();
    vectors++; if ({bus.vend_req, bus.chg_req, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL t3_done: got %b expected 000", {bus.vend_req, bus.chg_req, bus.busy}); end
  endtask

  task automatic test_timeout();
    put(0, 1, 0); put(0, 1, 0);
    press(1, 0);
    vectors++; if ({bus.vend_req, bus.credit} !== {1'b1, 7'd0}) begin
      errors++; $display("FAIL t4_start: got req=%b credit=%0d expected 1/0", bus.vend_req, bus.credit); end
    repeat (15) cycle();
    vectors++; if ({bus.vend_req, bus.vend_fail} !== 2'b10) begin
      errors++; $display("FAIL t4_cycle16: got %b expected 10", {bus.vend_req, bus.vend_fail}); end
    cycle();
    vectors++; if ({bus.vend_req, bus.vend_fail, bus.chg_req} !== 3'b011) begin
      errors++; $display("FAIL t4_expire: got %b expected 011", {bus.vend_req, bus.vend_fail, bus.chg_req}); end
    vectors++; if (bus.credit !== 7'd20) begin errors++; $display("FAIL t4_refund: got %0d expected 20", bus.credit); end
    cycle();
    vectors++; if (bus.vend_fail !== 1'b0) begin errors++; $display("FAIL t4_fail_pulse: got %b expected 0", bus.vend_fail); end
    for (int i = 1; i <= 4; i++) begin
      pulse_chg_ack();
      vectors++; if (bus.credit !== 7'(20 - 5 * i)) begin
        errors++; $display("FAIL t4_nickel%0d: got %0d expected %0d", i, bus.credit, 20 - 5 * i); end
    end
    vectors++; if ({bus.chg_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL t4_idle: got %b expected 00", {bus.chg_req, bus.busy}); end
  endtask

  task automatic test_sel_cancel();
    put(0, 1, 0); put(1, 0, 0);
    press(1, 0);
    vectors++; if ({bus.busy, bus.vend_req, bus.credit} !== {2'b00, 7'd15}) begin
      errors++; $display("FAIL t5_sel_poor: got busy=%b req=%b credit=%0d expected 0/0/15", bus.busy, bus.vend_req, bus.credit); end
    press(1, 1);
    vectors++; if ({bus.state, bus.chg_req, bus.vend_req} !== {PAYOUT, 2'b10}) begin
      errors++; $display("FAIL t5_cancel_wins: got state=%0d chg=%b vend=%b expected %0d/1/0", bus.state, bus.chg_req, bus.vend_req, PAYOUT); end
    repeat (3) pulse_chg_ack();
    vectors++; if ({bus.credit, bus.busy} !== {7'd0, 1'b0}) begin
      errors++; $display("FAIL t5_three_nickels: got credit=%0d busy=%b expected 0/0", bus.credit, bus.busy); end
    put(0, 1, 0); put(0, 1, 0);
    press(1, 1);
    vectors++; if ({bus.state, bus.vend_req, bus.chg_req, bus.credit} !== {VEND, 2'b10, 7'd0}) begin
      errors++; $display("FAIL t5_sel_wins: got state=%0d req=%b chg=%b credit=%0d expected %0d/1/0/0", bus.state, bus.vend_req, bus.chg_req, bus.credit, VEND); end
    pulse_vend_ack();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_back_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_sel_with_coin();
    put(0, 1, 0); put(0, 1, 0);
    bus.nin = 1'b1; bus.sel = 1'b1;
    cycle();
    bus.nin = 1'b0; bus.sel = 1'b0;
    vectors++; if ({bus.credit, bus.vend_req, bus.coin_rej} !== {7'd5, 2'b10}) begin
      errors++; $display("FAIL t7_sel_coin: got credit=%0d req=%b rej=%b expected 5/1/0", bus.credit, bus.vend_req, bus.coin_rej); end
    pulse_vend_ack();
    vectors++; if ({bus.state, bus.chg_req} !== {PAYOUT, 1'b1}) begin
      errors++; $display("FAIL t7_payout: got state=%0d chg=%b expected %0d/1", bus.state, bus.chg_req, PAYOUT); end
    pulse_chg_ack();
    vectors++; if ({bus.credit, bus.busy} !== {7'd0, 1'b0}) begin
      errors++; $display("FAIL t7_idle: got credit=%0d busy=%b expected 0/0", bus.credit, bus.busy); end
  endtask

  task automatic test_async_reset();
    put(0, 1, 0);
    press(0, 1);
    vectors++; if ({bus.chg_req, bus.credit} !== {1'b1, 7'd10}) begin
      errors++; $display("FAIL t6_setup: got chg=%b credit=%0d expected 1/10", bus.chg_req, bus.credit); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({bus.chg_req, bus.busy, bus.credit} !== {2'b00, 7'd0}) begin
      errors++; $display("FAIL t6_async: got chg=%b busy=%b credit=%0d expected 0/0/0", bus.chg_req, bus.busy, bus.credit); end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    vectors++; if (bus.state !== IDLE) begin errors++; $display("FAIL t6_release: got %0d expected %0d", bus.state, IDLE); end
    put(1, 0, 0);
    vectors++; if (bus.credit !== 7'd5) begin errors++; $display("FAIL t6_after_coin: got %0d expected 5", bus.credit); end
  endtask

  initial begin
    bus.nin = 1'b0; bus.din = 1'b0; bus.qin = 1'b0;
    bus.sel = 1'b0; bus.cancel = 1'b0;
    bus.vend_ack = 1'b0; bus.chg_ack = 1'b0;
    test_reset();
    test_vend_with_change();
    test_overflow();
    test_reject();
    test_timeout();
    test_sel_cancel();
    test_sel_with_coin();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
